if_stage: RTL

//  Instruction-fetch stage; directly upstream of decode via the IF/ID register.

---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 76 +++++++
 2 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bundle carrying pipeline control, memory handshake and IF/ID outputs.
interface if_stage_if;
  logic        stall_in;
  logic        jump_in;
  logic [31:0] jump_addr_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;
  modport master (
    input  stall_in, jump_in, jump_addr_in, mem_ack_in, mem_data_in,
    output mem_req_out, mem_addr_out, pc_out, inst_out, inst_valid_out
  );
  modport slave (
    output stall_in, jump_in, jump_addr_in, mem_ack_in, mem_data_in,
    input  mem_req_out, mem_addr_out, pc_out, inst_out, inst_valid_out
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a direct-mapped 1-word-line icache and single-word miss refill.
module if_stage #(
  parameter int          ICACHE_LINES = 64,
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter logic [31:0] NOP_INST     = 32'h00000013
) (
  input logic clk_in,
  input logic rst_in,
  if_stage_if.master bus
);
  localparam int IDX = $clog2(ICACHE_LINES);
  typedef enum logic {LOOKUP, MISS} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pc_out_nx, inst_out_nx, mem_addr_nx;
  logic valid_nx, req_nx, hit, fill;
  logic [ICACHE_LINES-1:0] line_valid;
  logic [29-IDX:0] tags [ICACHE_LINES];
  logic [31:0] lines [ICACHE_LINES];
  logic [IDX-1:0] idx, fill_idx;
  assign idx = pc[IDX+1:2];
  assign fill_idx = bus.mem_addr_out[IDX+1:2];
  assign hit = line_valid[idx] && tags[idx] == pc[31:IDX+2];
  // A jump during MISS only retargets pc; the in-flight refill still lands in the cache.
  assign fill = state == MISS && bus.mem_ack_in;
  always_comb begin
    state_nx = state;
    pc_nx = bus.jump_in ? (bus.jump_addr_in & ~32'h3) : pc;
    pc_out_nx = bus.pc_out;
    inst_out_nx = (bus.jump_in || !bus.stall_in) ? NOP_INST : bus.inst_out;
    valid_nx = (bus.jump_in || !bus.stall_in) ? 1'b0 : bus.inst_valid_out;
    req_nx = bus.mem_req_out;
    mem_addr_nx = bus.mem_addr_out;
    if (state == LOOKUP && !bus.jump_in && !bus.stall_in) begin
      if (hit) begin
        pc_out_nx = pc;
        inst_out_nx = lines[idx];
        valid_nx = 1'b1;
        pc_nx = pc + 32'd4;
      end else begin
        req_nx = 1'b1;
        mem_addr_nx = pc;
        state_nx = MISS;
      end
    end else if (fill) begin
      req_nx = 1'b0;
      state_nx = LOOKUP;
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= LOOKUP;
      pc <= RESET_PC;
      line_valid <= '0;
      bus.pc_out <= '0;
      bus.inst_out <= NOP_INST;
      bus.inst_valid_out <= 1'b0;
      bus.mem_req_out <= 1'b0;
      bus.mem_addr_out <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if (fill) line_valid[fill_idx] <= 1'b1;
      bus.pc_out <= pc_out_nx;
      bus.inst_out <= inst_out_nx;
      bus.inst_valid_out <= valid_nx;
      bus.mem_req_out <= req_nx;
      bus.mem_addr_out <= mem_addr_nx;
    end
  end
  always_ff @(posedge clk_in) begin
    if (fill) begin
      lines[fill_idx] <= bus.mem_data_in;
      tags[fill_idx] <= bus.mem_addr_out[31:IDX+2];
    end
  end
endmodule
